xadc_scan_sequencer: RTL
========================

Name: xadc_scan_sequencer

Overview:
- Sequences the XADC dynamic reconfiguration port (DRP) to read the four auxiliary audio channels in turn: VAUX6, VAUX7, VAUX15, VAUX14.
- Each sweep is triggered by the XADC end-of-conversion pulse.
- Holds the latest 12-bit result per channel and signals frame completion.
- Sits between the XADC primitive and the downstream consumers: the LED/PWM driver, which takes channel 1, and the display/LED logic.

Parameters:
- TIMEOUT_CYC, 64, maximum cycles to wait for drdy after a read request before abandoning that channel.
- NUM_CH, 4, channels per sweep; fixed at 4 and kept as a parameter for readability.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- eoc  input  1  XADC end-of-conversion, single-cycle pulse
- den  output  1  DRP enable, one-cycle pulse per read
- dwe  output  1  DRP write enable, constant 0
- daddr  output  7  DRP address
- drdy  input  1  DRP data ready
- do_data  input  16  DRP read data; the result is in bits [15:4]
- ch_data  output  64  four 16-bit results; slot 0 = VAUX6 in [15:0], slot 1 = VAUX7, slot 2 = VAUX15, slot 3 = VAUX14
- frame_valid  output  1  one-cycle pulse after all four slots have been updated in a sweep
- busy  output  1  high in every state except IDLE
- err_timeout  output  1  sticky; set when any read times out
- overrun  output  1  sticky; set when eoc arrives while a pending trigger is already latched

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, channel index = 0, den = 0, daddr = 0x16, dwe = 0.
  - ch_data = 0, frame_valid = 0, busy = 0, err_timeout = 0, overrun = 0, pending = 0, timeout counter = 0.
  - Reset asserted mid-sweep aborts the sweep immediately.
  - A drdy arriving after that reset is ignored.
- States: IDLE, REQ, WAIT, STORE, FRAME.
- IDLE: when eoc = 1 at edge t, go to REQ at t+1 with index = 0.
- REQ (1 cycle):
  - den = 1, daddr = address of the current index (0x16, 0x17, 0x1F, 0x1E for index 0..3).
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - daddr holds its value; den = 0; the counter increments each cycle.
  - If drdy = 1, capture do_data[15:4] zero-extended into a staging register and go to STORE.
  - Otherwise, if the counter reaches TIMEOUT_CYC-1, set err_timeout, leave the slot unchanged, and go to STORE flagged as no-write.
- STORE (1 cycle):
  - Write the staging register into slot[index] unless flagged as no-write.
  - If index = 3, go to FRAME; otherwise index += 1 and go to REQ.
- FRAME (1 cycle):
  - frame_valid = 1.
  - If pending = 1, clear pending, set index = 0, and go to REQ; otherwise go to IDLE.
- Latency: eoc at edge t gives den high during cycle t+1. drdy at cycle k gives the slot updated and visible from k+1. frame_valid is asserted the cycle after slot 3 is written.
- eoc while busy:
  - If pending = 0, set pending = 1.
  - If pending = 1, set overrun = 1; the extra trigger is dropped.
  - eoc in the FRAME cycle counts as busy.
- drdy outside WAIT is ignored. den is never asserted while a read is outstanding.
- Sticky flags clear only on rst.
- Slots update one at a time, so ch_data may be mixed-sweep between frame_valid pulses. Consumers sample on frame_valid.

Optional Feature:
- Macro: XADC_AVG_EN.
- Defined:
  - Each slot gets an 18-bit accumulator that adds the captured sample on every STORE.
  - After the 4th completed sweep, slot = accumulator >> 2 (truncating), accumulators clear, and frame_valid pulses.
  - frame_valid therefore pulses once per 4 sweeps. A sweep counter (2 bits) resets to 0.
  - A timed-out read adds the slot's previous output value instead of a new sample.
- Undefined: behaviour exactly as above; no accumulators are synthesised.

Decomposition:
- Package xadc_pkg:
  - state enum (IDLE, REQ, WAIT, STORE, FRAME).
  - channel address constants ADDR_VAUX6 = 7'h16, ADDR_VAUX7 = 7'h17, ADDR_VAUX15 = 7'h1F, ADDR_VAUX14 = 7'h1E.
  - slot index constants.
  - sample width constant 12.
- One sub-module, xadc_slot_avg, holds per-slot accumulate/divide. It is instantiated four times, only under XADC_AVG_EN.

Test Plan:
- Reset, then a single eoc with a DRP model answering drdy 3 cycles after den and returning 0xA5F0, 0x1230, 0xFFF0, 0x0010:
  - ch_data = {0x0001, 0x0FFF, 0x0123, 0x0A5F}.
  - den pulses exactly 4 times with daddr 0x16, 0x17, 0x1F, 0x1E.
  - Exactly one frame_valid pulse.
- DRP model never answers slot 2, with TIMEOUT_CYC = 64:
  - 64 WAIT cycles, then err_timeout = 1.
  - Slot 2 keeps its previous value; slots 0, 1, 3 update; frame_valid still pulses.
- Two eoc pulses during one sweep, then a third:
  - One back-to-back sweep starts in the cycle after FRAME.
  - overrun = 1 after the second extra eoc.
  - Total frame_valid pulses = 2.
- rst asserted while in WAIT for slot 1, followed by a late drdy:
  - All outputs return to their reset values; the late drdy is ignored; state stays IDLE until the next eoc.
- Stray drdy pulses in IDLE and during REQ:
  - No slot changes, no state change.
- With XADC_AVG_EN, four sweeps with slot 0 samples 100, 200, 300, 401:
  - frame_valid only after sweep 4.
  - Slot 0 = 250 (1001 >> 2).

Source files
------------

// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC auxiliary-channel DRP sequencer.
// Channel order: VAUX6, VAUX7, VAUX15, VAUX14.
package xadc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        STORE,
        FRAME
    } state_t;

    localparam logic [6:0] ADDR_VAUX6  = 7'h16;
    localparam logic [6:0] ADDR_VAUX7  = 7'h17;
    localparam logic [6:0] ADDR_VAUX15 = 7'h1F;
    localparam logic [6:0] ADDR_VAUX14 = 7'h1E;

    localparam logic [1:0] SLOT_VAUX6  = 2'd0;
    localparam logic [1:0] SLOT_VAUX7  = 2'd1;
    localparam logic [1:0] SLOT_VAUX15 = 2'd2;
    localparam logic [1:0] SLOT_VAUX14 = 2'd3;

    localparam int SAMPLE_W = 12;

    function automatic logic [6:0] ch_addr(input logic [1:0] idx);
        case (idx)
            SLOT_VAUX6:  return ADDR_VAUX6;
            SLOT_VAUX7:  return ADDR_VAUX7;
            SLOT_VAUX15: return ADDR_VAUX15;
            default:     return ADDR_VAUX14;
        endcase
    endfunction

endpackage

// File: rtl/xadc_slot_avg.sv
// Per-slot 4-sweep accumulator; publishes sum >> 2 on dump.
// Used by xadc_scan_sequencer only when XADC_AVG_EN is defined.
module xadc_slot_avg
    import xadc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                add_en,
    input  logic                use_prev,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                dump,
    output logic [15:0]         slot
);

    logic [17:0]         acc_q, acc_d;
    logic [15:0]         avg_q, avg_d;
    logic [SAMPLE_W-1:0] add_val;
    logic [17:0]         sum;

    always_comb begin
        add_val = use_prev ? avg_q[SAMPLE_W-1:0] : sample;
        sum     = acc_q + (add_en ? {6'b0, add_val} : 18'd0);
        acc_d   = add_en ? sum : acc_q;
        avg_d   = avg_q;
        // dump coincides with the last slot's add, so use the summed value
        if (dump) begin
            acc_d = '0;
            avg_d = sum[17:2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            avg_q <= '0;
        end else begin
            acc_q <= acc_d;
            avg_q <= avg_d;
        end
    end

    assign slot = avg_q;

endmodule

// File: rtl/xadc_scan_sequencer.sv
// DRP read sequencer for the four XADC auxiliary audio channels.
// Define XADC_AVG_EN to average each slot over four sweeps.
module xadc_scan_sequencer
    import xadc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int NUM_CH      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eoc,
    output logic        den,
    output logic        dwe,
    output logic [6:0]  daddr,
    input  logic        drdy,
    input  logic [15:0] do_data,
    output logic [63:0] ch_data,
    output logic        frame_valid,
    output logic        busy,
    output logic        err_timeout,
    output logic        overrun
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]       LAST_IDX = 2'(NUM_CH - 1);

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic                den_q, den_d;
    logic [6:0]          daddr_q, daddr_d;
    logic [CNT_W-1:0]    tmo_q, tmo_d;
    logic [SAMPLE_W-1:0] stage_q, stage_d;
    logic                nowr_q, nowr_d;
    logic                fv_q, fv_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                ovr_q, ovr_d;
    logic                pend_q, pend_d;
    logic                frame_hit;
    logic                unused_lsb;

    assign unused_lsb = ^do_data[3:0];

`ifdef XADC_AVG_EN
    logic [1:0] sweep_q, sweep_d;
    logic       dump;

    assign dump      = (state_q == STORE) && (idx_q == LAST_IDX)
                       && (sweep_q == 2'd3);
    assign frame_hit = dump;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_avg
        xadc_slot_avg u_avg (
            .clk      (clk),
            .rst      (rst),
            .add_en   ((state_q == STORE) && (idx_q == 2'(g))),
            .use_prev (nowr_q),
            .sample   (stage_q),
            .dump     (dump),
            .slot     (ch_data[16*g +: 16])
        );
    end
`else
    logic [63:0] ch_data_q, ch_data_d;

    assign frame_hit = 1'b1;
    assign ch_data   = ch_data_q;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        stage_d = stage_q;
        nowr_d  = nowr_q;
        err_d   = err_q;
        ovr_d   = ovr_q;
        pend_d  = pend_q;
        fv_d    = 1'b0;
`ifdef XADC_AVG_EN
        sweep_d = sweep_q;
`else
        ch_data_d = ch_data_q;
`endif

        // one trigger may queue behind the running sweep; more are dropped
        if (eoc && (state_q != IDLE || pend_q)) begin
            if (pend_q) ovr_d  = 1'b1;
            else        pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (eoc || pend_q) begin
                    state_d = REQ;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            REQ: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (drdy) begin
                    stage_d = do_data[15:4];
                    nowr_d  = 1'b0;
                    state_d = STORE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    nowr_d  = 1'b1;
                    state_d = STORE;
                end
            end
            STORE: begin
`ifndef XADC_AVG_EN
                if (!nowr_q)
                    ch_data_d[{idx_q, 4'b0} +: 16] = {4'b0, stage_q};
`endif
                if (idx_q == LAST_IDX) begin
                    state_d = FRAME;
                    fv_d    = frame_hit;
`ifdef XADC_AVG_EN
                    sweep_d = sweep_q + 1'b1;
`endif
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = REQ;
                end
            end
            FRAME: begin
                if (pend_q) begin
                    pend_d  = 1'b0;
                    idx_d   = '0;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        den_d   = (state_d == REQ);
        daddr_d = den_d ? ch_addr(idx_d) : daddr_q;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            den_q     <= 1'b0;
            daddr_q   <= ADDR_VAUX6;
            tmo_q     <= '0;
            stage_q   <= '0;
            nowr_q    <= 1'b0;
            fv_q      <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
            pend_q    <= 1'b0;
`ifdef XADC_AVG_EN
            sweep_q   <= '0;
`else
            ch_data_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            den_q     <= den_d;
            daddr_q   <= daddr_d;
            tmo_q     <= tmo_d;
            stage_q   <= stage_d;
            nowr_q    <= nowr_d;
            fv_q      <= fv_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
            pend_q    <= pend_d;
`ifdef XADC_AVG_EN
            sweep_q   <= sweep_d;
`else
            ch_data_q <= ch_data_d;
`endif
        end
    end

    assign den         = den_q;
    assign dwe         = 1'b0;
    assign daddr       = daddr_q;
    assign frame_valid = fv_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;
    assign overrun     = ovr_q;

endmodule
